gpa_fhdo_spi_slave: RTL

Synthesizable SPI slave model of the GPA-FHDO DAC80504 side: it decodes the 24-bit frames produced by the gradient SPI master, keeps the DAC and SYNC register file, and presents the resulting channel values in parallel. It sits in the loopback/test build between the master's `fhd_*` pins and a checker or BRAM capture, so the gradient path can be verified in hardware without the board. Optional readback drives the slave data line for two-frame register reads.

---
 rtl/gpa_fhdo_spi_slave.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/gpa_fhdo_spi_slave.sv
// SPI slave model of the GPA-FHDO DAC80504: decodes 24-bit frames into a DAC/SYNC register file.
// Define GPA_FHDO_SLAVE_READBACK_EN to enable two-frame register readback on fhd_sdi_o.
module gpa_fhdo_spi_slave #(
    parameter logic [15:0] SYNC_RST = 16'hFF00,
    parameter logic [15:0] DEV_ID   = 16'h0815
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fhd_clk_i,
    input  logic        fhd_sdo_i,
    input  logic        fhd_csn_i,
    output logic        fhd_sdi_o,
    input  logic        ldac_n_i,
    output logic [63:0] dac_data_o,
    output logic [3:0]  dac_update_o,
    output logic [15:0] sync_reg_o,
    output logic [7:0]  frame_err_cnt_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    // Two-flop synchronizers plus one history flop per edge-detected input
    logic sclk_m_q, sclk_s_q, sclk_p_q;
    logic sdo_m_q, sdo_s_q;
    logic csn_m_q, csn_s_q, csn_p_q;
    logic ldac_m_q, ldac_s_q, ldac_p_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_m_q <= 1'b1;
            sclk_s_q <= 1'b1;
            sclk_p_q <= 1'b1;
            sdo_m_q  <= 1'b0;
            sdo_s_q  <= 1'b0;
            csn_m_q  <= 1'b1;
            csn_s_q  <= 1'b1;
            csn_p_q  <= 1'b1;
            ldac_m_q <= 1'b1;
            ldac_s_q <= 1'b1;
            ldac_p_q <= 1'b1;
        end else begin
            sclk_m_q <= fhd_clk_i;
            sclk_s_q <= sclk_m_q;
            sclk_p_q <= sclk_s_q;
            sdo_m_q  <= fhd_sdo_i;
            sdo_s_q  <= sdo_m_q;
            csn_m_q  <= fhd_csn_i;
            csn_s_q  <= csn_m_q;
            csn_p_q  <= csn_s_q;
            ldac_m_q <= ldac_n_i;
            ldac_s_q <= ldac_m_q;
            ldac_p_q <= ldac_s_q;
        end
    end

    logic sclk_fall, csn_fall, csn_rise, ldac_fall;
    assign sclk_fall = sclk_p_q & ~sclk_s_q;
    assign csn_fall  = csn_p_q & ~csn_s_q;
    assign csn_rise  = ~csn_p_q & csn_s_q;
    assign ldac_fall = ldac_p_q & ~ldac_s_q;
    assign busy_o    = ~csn_s_q;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [23:0] shreg_q, shreg_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (csn_fall) state_d = SHIFT;
            SHIFT:   if (csn_rise) state_d = COMMIT;
            COMMIT:  state_d = csn_fall ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        if (csn_fall) begin
            cnt_d   = '0;
            shreg_d = '0;
        end else if (state_q == SHIFT && sclk_fall) begin
            shreg_d = {shreg_q[22:0], sdo_s_q};
            if (cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    logic             commit_ok, frame_bad, ldac_q;
    logic [3:0]       wr_addr;
    logic [1:0]       wr_ch;
    logic [15:0]      wr_data;
    logic [3:0][15:0] dac_q, dac_d, buf_q, buf_d;
    logic [3:0]       pend_q, pend_d, upd_q, upd_d, sync_en;
    logic [15:0]      sync_q, sync_d;
    logic [7:0]       err_q, err_d;

    assign commit_ok = (state_q == COMMIT) && (cnt_q == 5'd24);
    assign frame_bad = (state_q == COMMIT) && (cnt_q != 5'd24);
    assign wr_addr   = shreg_q[19:16];
    assign wr_ch     = shreg_q[17:16];
    assign wr_data   = shreg_q[15:0];
    assign sync_en   = sync_q[3:0];

    // LDAC transfer is applied before the frame write so a same-cycle synced write stays pending
    always_comb begin
        dac_d  = dac_q;
        buf_d  = buf_q;
        pend_d = pend_q;
        upd_d  = '0;
        sync_d = sync_q;
        err_d  = err_q;
        if (ldac_q) begin
            for (int unsigned c = 0; c < 4; c++) begin
                if (pend_q[2'(c)]) begin
                    dac_d[2'(c)]  = buf_q[2'(c)];
                    upd_d[2'(c)]  = 1'b1;
                    pend_d[2'(c)] = 1'b0;
                end
            end
        end
        if (commit_ok && !shreg_q[23]) begin
            if (wr_addr == 4'h2) begin
                sync_d = wr_data;
            end else if (wr_addr[3:2] == 2'b10) begin
                if (sync_en[wr_ch]) begin
                    buf_d[wr_ch]  = wr_data;
                    pend_d[wr_ch] = 1'b1;
                end else begin
                    dac_d[wr_ch]  = wr_data;
                    upd_d[wr_ch]  = 1'b1;
                end
            end
        end
        if (frame_bad && err_q != 8'hFF) err_d = err_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ldac_q <= 1'b0;
            dac_q  <= '0;
            buf_q  <= '0;
            pend_q <= '0;
            upd_q  <= '0;
            sync_q <= SYNC_RST;
            err_q  <= '0;
        end else begin
            ldac_q <= ldac_fall;
            dac_q  <= dac_d;
            buf_q  <= buf_d;
            pend_q <= pend_d;
            upd_q  <= upd_d;
            sync_q <= sync_d;
            err_q  <= err_d;
        end
    end

    assign dac_data_o      = dac_q;
    assign dac_update_o    = upd_q;
    assign sync_reg_o      = sync_q;
    assign frame_err_cnt_o = err_q;

`ifdef GPA_FHDO_SLAVE_READBACK_EN
    logic        sclk_rise, sdi_q, sdi_d;
    logic [3:0]  rd_addr_q, rd_addr_d;
    logic [22:0] tx_q, tx_d;
    logic [15:0] rb_val;
    logic        unused_fields;

    assign sclk_rise     = ~sclk_p_q & sclk_s_q;
    assign unused_fields = ^shreg_q[22:20];

    always_comb begin
        case (rd_addr_q)
            4'h1:                   rb_val = DEV_ID;
            4'h2:                   rb_val = sync_q;
            4'h8, 4'h9, 4'hA, 4'hB: rb_val = dac_q[rd_addr_q[1:0]];
            default:                rb_val = '0;
        endcase
    end

    // Bit 23 is the constant read marker; the remaining 23 bits are snapshotted at frame start
    always_comb begin
        rd_addr_d = rd_addr_q;
        tx_d      = tx_q;
        sdi_d     = sdi_q;
        if (commit_ok && shreg_q[23]) rd_addr_d = wr_addr;
        if (csn_fall) begin
            tx_d  = {3'b000, rd_addr_q, rb_val};
            sdi_d = 1'b1;
        end else if (state_q == SHIFT && sclk_rise) begin
            tx_d  = {tx_q[21:0], 1'b0};
            sdi_d = tx_q[22];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_q <= '0;
            tx_q      <= '0;
            sdi_q     <= 1'b0;
        end else begin
            rd_addr_q <= rd_addr_d;
            tx_q      <= tx_d;
            sdi_q     <= sdi_d;
        end
    end

    assign fhd_sdi_o = sdi_q;
`else
    logic unused_fields;
    assign unused_fields = ^{shreg_q[22:20], DEV_ID};
    assign fhd_sdi_o     = 1'b0;
`endif

endmodule
